load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have one clock, clk; reset is rst, synchronous, active-high.
REQ-002 SHALL expose ports, clock and reset first:
  clk  in  1  system clock, rising edge
  rst  in  1  synchronous active-high reset
  req  in  1  pipeline access request, sampled only in IDLE
  op  in  3  access type: LW, LH, LHU, LB, LBU, SW, SH, SB
  addr  in  32  byte address
  st_data  in  32  store data, low-aligned (SB uses [7:0], SH uses [15:0])
  busy  out  1  high whenever state is not IDLE; pipeline stalls on it
  done  out  1  one-cycle completion pulse
  ld_data  out  32  extended load result, valid while done=1
  misaligned  out  1  alignment fault flag, valid while done=1
  addr_in  out  32  word address to MEM
  wr_data  out  32  write word to MEM
  MemWrite  out  1  MEM write strobe
  MemRead  out  1  MEM read strobe
  rd_data  in  32  MEM read word, valid one cycle after MemRead

Function
REQ-003 SHALL accept a request only when state=IDLE and req=1; req while busy SHALL be ignored.
REQ-004 SHALL latch op, addr and st_data at accept; later input changes SHALL NOT affect the access.
REQ-005 SHALL drive addr_in = {addr[31:2], 2'b00} from the latched address.
REQ-006 SHALL use big-endian lanes: byte 0 = [31:24], byte 3 = [7:0]; half 0 = [31:16], half 2 = [15:0].
REQ-007 SHALL implement states IDLE, READ, CAPTURE, WRITE, DONE.
REQ-008 SHALL sequence loads IDLE->READ->CAPTURE->DONE->IDLE; with accept at edge T, done=1 in cycle T+3.
REQ-009 SHALL sequence SW IDLE->WRITE->DONE->IDLE; done=1 in cycle T+2.
REQ-010 SHALL sequence SB/SH as read-modify-write IDLE->READ->CAPTURE->WRITE->DONE; done=1 in cycle T+4.
REQ-011 SHALL assert MemRead only in READ and MemWrite only in WRITE, each for exactly one cycle, never both together.
REQ-012 SHALL sample rd_data in CAPTURE: loads extract the lane; SB/SH merge st_data into the addressed lane, other lanes unchanged.
REQ-013 SHALL zero-extend LBU/LHU, sign-extend LB/LH, and pass LW through unchanged.
REQ-014 SHALL flag misalignment when LW/SW have addr[1:0]!=0 or LH/LHU/SH have addr[0]!=0.
REQ-015 SHALL handle a misaligned access as IDLE->DONE: no MemRead/MemWrite, done and misaligned high in T+1, ld_data held.
REQ-016 SHALL hold ld_data between completions and drive misaligned=0 when done=0.
REQ-017 SHALL allow a new accept in the cycle after DONE, giving back-to-back issue with one IDLE cycle.

Reset
REQ-018 SHALL force state=IDLE and busy, done, misaligned, MemRead, MemWrite=0 on rst.
REQ-019 SHALL clear ld_data, addr_in and wr_data to 0 on rst.
REQ-020 SHALL on rst mid-operation, including in WRITE, drop strobes at that edge; no partial write completes and no done pulse is issued.

Structure
REQ-021 SHALL take op encodings (LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7) and the state enum from shared package mips_mem_pkg.
REQ-022 SHALL put lane extract/extend and store merge in one combinational sub-module, lsu_align, instantiated once.

Verification
REQ-023 SHALL cover SW addr=0x0, st_data=0x000000AA -> MemWrite one cycle at T+1, addr_in=0x0, wr_data=0xAA, done at T+2.
REQ-024 SHALL cover LW addr=0x4 with MEM word 0x0000BEEF -> MemRead at T+1, done at T+3, ld_data=0x0000BEEF.
REQ-025 SHALL cover SB addr=0x9, st_data=0x5A with MEM[0x8]=0x00000BAD -> MemRead, then MemWrite wr_data=0x005A0BAD, done at T+4.
REQ-026 SHALL cover LB/LBU addr=0xA with word 0x11F02233 (lane = 0x22) and with word 0x1122F033 (lane = 0xF0) -> LB=0x00000022 and 0xFFFFFFF0, LBU=0x00000022 and 0x000000F0.
REQ-027 SHALL cover LH addr=0x3 -> no MEM strobes, done and misaligned in T+1; then SH addr=0x2 st_data=0x8001 over 0xAAAAAAAA -> wr_data=0xAAAA8001.
REQ-028 SHALL cover rst during WRITE of an SB -> MemWrite low next cycle, MEM word unchanged, busy=0, no done pulse.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types for the load/store path: access opcodes, LSU states and
// the alignment/classification helpers used by the LSU.
package mips_mem_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LH  = 3'd1,
        OP_LHU = 3'd2,
        OP_LB  = 3'd3,
        OP_LBU = 3'd4,
        OP_SW  = 3'd5,
        OP_SH  = 3'd6,
        OP_SB  = 3'd7
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_WRITE,
        S_DONE
    } state_t;

    function automatic logic is_load(input op_t op);
        return op inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
    endfunction

    function automatic logic is_misaligned(input op_t op, input logic [1:0] off);
        case (op)
            OP_LW, OP_SW:         return off != 2'b00;
            OP_LH, OP_LHU, OP_SH: return off[0];
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Big-endian lane handling: extracts and extends load lanes from a memory
// word, and merges sub-word store data into a read-back word.
module lsu_align
    import mips_mem_pkg::*;
(
    input  op_t         op,
    input  logic [1:0]  byte_off,
    input  logic [31:0] word,
    input  logic [15:0] st_data,
    output logic [31:0] ld_result,
    output logic [31:0] merged
);

    // Byte 0 sits in the most significant lane, so the lane LSB is (3-off)*8.
    logic [4:0]  byte_lsb;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign byte_lsb = {~byte_off, 3'b000};
    assign lane_b   = word[byte_lsb +: 8];
    assign lane_h   = byte_off[1] ? word[15:0] : word[31:16];

    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        ld_result = word;
        merged    = word;
        case (op)
            OP_LH:  ld_result = {{16{lane_h[15]}}, lane_h};
            OP_LHU: ld_result = {16'h0000, lane_h};
            OP_LB:  ld_result = {{24{lane_b[7]}}, lane_b};
            OP_LBU: ld_result = {24'h000000, lane_b};
            OP_SH: begin
                if (byte_off[1]) merged[15:0]  = st_data;
                else             merged[31:16] = st_data;
            end
            OP_SB:  merged[byte_lsb +: 8] = st_data[7:0];
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: word-addressed MEM handshake, sub-word
// loads with extension, and read-modify-write for byte/half stores.
module load_store_unit
    import mips_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] st_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] ld_data,
    output logic        misaligned,
    output logic [31:0] addr_in,
    output logic [31:0] wr_data,
    output logic        MemWrite,
    output logic        MemRead,
    input  logic [31:0] rd_data
);

    state_t      state;
    op_t         op_q;
    logic [1:0]  off_q;
    logic [15:0] st_low_q;
    logic [31:0] ld_result;
    logic [31:0] merged;

    lsu_align u_align (
        .op        (op_q),
        .byte_off  (off_q),
        .word      (rd_data),
        .st_data   (st_low_q),
        .ld_result (ld_result),
        .merged    (merged)
    );

    assign busy = (state != S_IDLE);

    // Strobes and done are decoded one edge early so they leave a flop.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            state      <= S_IDLE;
            done       <= 1'b0;
            misaligned <= 1'b0;
            MemRead    <= 1'b0;
            MemWrite   <= 1'b0;
            ld_data    <= '0;
            addr_in    <= '0;
            wr_data    <= '0;
            op_q       <= OP_LW;
            off_q      <= '0;
            st_low_q   <= '0;
        end else begin
            done       <= 1'b0;
            misaligned <= 1'b0;
            MemRead    <= 1'b0;
            MemWrite   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        op_q     <= op_t'(op);
                        off_q    <= addr[1:0];
                        st_low_q <= st_data[15:0];
                        addr_in  <= {addr[31:2], 2'b00};
                        if (is_misaligned(op_t'(op), addr[1:0])) begin
                            state      <= S_DONE;
                            done       <= 1'b1;
                            misaligned <= 1'b1;
                        end else if (op_t'(op) == OP_SW) begin
                            state    <= S_WRITE;
                            MemWrite <= 1'b1;
                            wr_data  <= st_data;
                        end else begin
                            state   <= S_READ;
                            MemRead <= 1'b1;
                        end
                    end
                end
                S_READ: state <= S_CAPTURE;
                S_CAPTURE: begin
                    if (is_load(op_q)) begin
                        ld_data <= ld_result;
                        state   <= S_DONE;
                        done    <= 1'b1;
                    end else begin
                        wr_data  <= merged;
                        state    <= S_WRITE;
                        MemWrite <= 1'b1;
                    end
                end
                S_WRITE: begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a word-level memory model, an
// arithmetic reference for lanes/extension/merge, and a decoupled monitor.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] st_data;
    logic        busy;
    logic        done;
    logic [31:0] ld_data;
    logic        misaligned;
    logic [31:0] addr_in;
    logic [31:0] wr_data;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] rd_data = 32'h0;

    load_store_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .op         (op),
        .addr       (addr),
        .st_data    (st_data),
        .busy       (busy),
        .done       (done),
        .ld_data    (ld_data),
        .misaligned (misaligned),
        .addr_in    (addr_in),
        .wr_data    (wr_data),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // MEM: 16 words, one-cycle read latency; a write coinciding with reset is dropped.
    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];
    logic        bd_we = 1'b0;
    logic [3:0]  bd_idx = 4'h0;
    logic [31:0] bd_val = 32'h0;

    always @(posedge clk) begin
        if (bd_we) mem[bd_idx] <= bd_val;
        if (MemWrite && !rst) mem[addr_in[5:2]] <= wr_data;
        if (MemRead) rd_data <= mem[addr_in[5:2]];
    end

    typedef struct { int unsigned cyc; logic mis; logic [31:0] ld; } exp_done_t;
    typedef struct { int unsigned cyc; logic [31:0] a; logic [31:0] d; } exp_bus_t;

    exp_done_t exp_q [$];
    exp_bus_t  rd_q [$];
    exp_bus_t  wr_q [$];

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;
    logic [31:0] model_ld = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: plain shift/mask arithmetic on big-endian byte numbering.
    function automatic bit ref_mis(input logic [2:0] o, input int off);
        if (o == 3'd0 || o == 3'd5) return (off % 4) != 0;
        if (o == 3'd1 || o == 3'd2 || o == 3'd6) return (off % 2) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] o, input logic [31:0] w, input int off);
        int unsigned b, h;
        b = (w >> (8 * (3 - off))) & 32'hFF;
        h = (off >= 2) ? (w & 32'hFFFF) : (w >> 16);
        case (o)
            3'd1:    return (h >= 32'h8000) ? h + 32'hFFFF0000 : h;
            3'd2:    return h;
            3'd3:    return (b >= 32'h80) ? b + 32'hFFFFFF00 : b;
            3'd4:    return b;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_store(input logic [2:0] o, input logic [31:0] w,
                                              input int off, input logic [31:0] d);
        int sh;
        if (o == 3'd7) begin
            sh = 8 * (3 - off);
            return (w & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
        end
        if (o == 3'd6) begin
            sh = (off >= 2) ? 0 : 16;
            return (w & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
        end
        return d;
    endfunction

    task automatic poke(input int idx, input logic [31:0] val);
        bd_we  = 1'b1;
        bd_idx = 4'(idx);
        bd_val = val;
        @(negedge clk);
        bd_we = 1'b0;
        ref_mem[idx] = val;
    endtask

    // Issue one access at a negedge; expectations are queued at issue time.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                         input bit abort, output int unsigned t);
        bit ok;
        int off, idx;
        logic [31:0] wa, nw;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) check("issue_wait_idle", 32'(busy), 32'h0);
        t   = cyc;
        off = int'(a[1:0]);
        idx = int'(a[5:2]);
        wa  = {a[31:2], 2'b00};
        req = 1'b1; op = o; addr = a; st_data = d;
        if (ref_mis(o, off)) begin
            exp_q.push_back('{t + 1, 1'b1, model_ld});
        end else if (o == 3'd5) begin
            wr_q.push_back('{t + 1, wa, d});
            if (!abort) begin
                ref_mem[idx] = d;
                exp_q.push_back('{t + 2, 1'b0, model_ld});
            end
        end else if (o <= 3'd4) begin
            rd_q.push_back('{t + 1, wa, 32'h0});
            model_ld = ref_load(o, ref_mem[idx], off);
            exp_q.push_back('{t + 3, 1'b0, model_ld});
        end else begin
            nw = ref_store(o, ref_mem[idx], off, d);
            rd_q.push_back('{t + 1, wa, 32'h0});
            wr_q.push_back('{t + 3, wa, nw});
            if (!abort) begin
                ref_mem[idx] = nw;
                exp_q.push_back('{t + 4, 1'b0, model_ld});
            end
        end
        // Inputs change while busy: the access must use the latched values
        // and the held-high req must be ignored.
        @(negedge clk);
        req = 1'b1; op = 3'($urandom_range(7, 0)); addr = $urandom; st_data = $urandom;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin ok = 1'b1; break; end
        end
        if (!ok) check({name, "_timeout"}, 32'(exp_q.size()), 32'h0);
    endtask

    // Monitor: samples on the falling edge and pops whatever the DUT presents.
    initial begin : monitor
        logic [31:0] held_ld;
        bit rst_edge;
        exp_done_t e;
        exp_bus_t  b;
        held_ld = 32'h0;
        forever begin
            @(posedge clk);
            rst_edge = rst;
            @(negedge clk);
            if (rst_edge) held_ld = 32'h0;
            if (mon_en) begin
                if (MemRead && MemWrite) check("strobes_exclusive", 32'h1, 32'h0);
                if (MemRead) begin
                    if (rd_q.size() == 0) check("unexpected_memread", 32'h1, 32'h0);
                    else begin
                        b = rd_q.pop_front();
                        check("memread_cycle", cyc, b.cyc);
                        check("memread_addr", addr_in, b.a);
                    end
                end
                if (MemWrite) begin
                    if (wr_q.size() == 0) check("unexpected_memwrite", 32'h1, 32'h0);
                    else begin
                        b = wr_q.pop_front();
                        check("memwrite_cycle", cyc, b.cyc);
                        check("memwrite_addr", addr_in, b.a);
                        check("memwrite_data", wr_data, b.d);
                    end
                end
                if (done) begin
                    if (exp_q.size() == 0) check("unexpected_done", 32'h1, 32'h0);
                    else begin
                        e = exp_q.pop_front();
                        check("done_cycle", cyc, e.cyc);
                        check("done_misaligned", 32'(misaligned), 32'(e.mis));
                        check("done_ld_data", ld_data, e.ld);
                        held_ld = e.ld;
                    end
                end else begin
                    if (misaligned) check("misaligned_without_done", 32'h1, 32'h0);
                    if (ld_data !== held_ld) check("ld_data_hold", ld_data, held_ld);
                end
            end
        end
    end

    initial begin : stimulus
        int unsigned t;
        logic [31:0] pre;
        logic [2:0]  ro;
        rst = 1'b1; req = 1'b0; op = 3'd0; addr = 32'h0; st_data = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_misaligned", 32'(misaligned), 32'h0);
        check("reset_strobes", {30'h0, MemRead, MemWrite}, 32'h0);
        check("reset_ld_data", ld_data, 32'h0);
        check("reset_addr_in", addr_in, 32'h0);
        check("reset_wr_data", wr_data, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) poke(i, 32'h0);
        mon_en = 1'b1;

        // SW of a byte value to word 0.
        issue(3'd5, 32'h0, 32'h000000AA, 1'b0, t);
        wait_idle("sw_basic");
        check("sw_basic_mem", mem[0], 32'h000000AA);

        // LW returning a full word.
        poke(1, 32'h0000BEEF);
        issue(3'd0, 32'h4, 32'h0, 1'b0, t);
        wait_idle("lw_basic");
        check("lw_basic_ld", ld_data, 32'h0000BEEF);

        // SB read-modify-write into byte 1.
        poke(2, 32'h00000BAD);
        issue(3'd7, 32'h9, 32'h0000005A, 1'b0, t);
        wait_idle("sb_rmw");
        check("sb_rmw_mem", mem[2], 32'h005A0BAD);

        // LB/LBU on byte 2 with a positive and a negative lane.
        poke(2, 32'h11F02233);
        issue(3'd3, 32'hA, 32'h0, 1'b0, t);
        wait_idle("lb_pos");
        check("lb_pos_ld", ld_data, 32'h00000022);
        issue(3'd4, 32'hA, 32'h0, 1'b0, t);
        wait_idle("lbu_pos");
        check("lbu_pos_ld", ld_data, 32'h00000022);
        poke(2, 32'h1122F033);
        issue(3'd3, 32'hA, 32'h0, 1'b0, t);
        wait_idle("lb_neg");
        check("lb_neg_ld", ld_data, 32'hFFFFFFF0);
        issue(3'd4, 32'hA, 32'h0, 1'b0, t);
        wait_idle("lbu_neg");
        check("lbu_neg_ld", ld_data, 32'h000000F0);

        // Misaligned LH, then SH into the low half.
        issue(3'd1, 32'h3, 32'h0, 1'b0, t);
        wait_idle("lh_misaligned");
        check("lh_misaligned_ld_held", ld_data, 32'h000000F0);
        poke(0, 32'hAAAAAAAA);
        issue(3'd6, 32'h2, 32'h00008001, 1'b0, t);
        wait_idle("sh_rmw");
        check("sh_rmw_mem", mem[0], 32'hAAAA8001);

        // Reset asserted while an SB sits in WRITE.
        pre = mem[4];
        issue(3'd7, 32'h11, 32'h00000077, 1'b1, t);
        while (cyc < t + 3) @(negedge clk);
        check("rst_mid_write_strobe", 32'(MemWrite), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_memwrite", 32'(MemWrite), 32'h0);
        check("rst_mid_busy", 32'(busy), 32'h0);
        check("rst_mid_done", 32'(done), 32'h0);
        check("rst_mid_ld_data", ld_data, 32'h0);
        check("rst_mid_wr_data", wr_data, 32'h0);
        repeat (3) @(negedge clk);
        check("rst_mid_mem_unchanged", mem[4], pre);
        model_ld = 32'h0;

        // Randomised traffic over a preloaded memory, issued back to back.
        for (int i = 0; i < 16; i++) poke(i, $urandom);
        for (int n = 0; n < 200; n++) begin
            ro = 3'($urandom_range(7, 0));
            issue(ro, 32'($urandom_range(63, 0)), $urandom, 1'b0, t);
        end
        wait_idle("random_drain");

        for (int i = 0; i < 16; i++) check($sformatf("final_mem_%0d", i), mem[i], ref_mem[i]);
        check("queues_drained", 32'(exp_q.size() + rd_q.size() + wr_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
